// File: rtl/uart_cmd_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_cmd_responder                                         |
// | Description : Host-side command responder at the user end of the UART   |
// |               FIFOs. Pops 5-byte command frames                          |
// |               (SYNC_CMD, CMD, ADDR, DATA, CHK) from the RX FIFO and      |
// |               executes register writes and reads on an internal          |
// |               register file. Every command frame is answered with a      |
// |               4-byte response frame (SYNC_RSP, STATUS, RDATA, RCHK)      |
// |               pushed into the TX FIFO.                                   |
// | Ports       : clk, rst              clock, synchronous active-high reset |
// |               rx_fifo_empty/_dout   RX FIFO status and read data         |
// |               rx_fifo_rd_en         RX FIFO pop strobe                   |
// |               tx_fifo_full          TX FIFO status                       |
// |               tx_fifo_wr_en/_din    TX FIFO push strobe and data         |
// |               reg_rd_addr/_data     fabric-side register read port       |
// |               busy                  high whenever not hunting for sync   |
// |               frame_done            pulse on the last response push      |
// |               frame_err             pulse on timeout or non-OK status    |
// |               err_count             saturating count of frame_err pulses |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_cmd_responder #(
   parameter int         NUM_REGS       = 16,
   parameter int         TIMEOUT_CYCLES = 50000,
   parameter logic [7:0] SYNC_CMD       = 8'hA5,
   parameter logic [7:0] SYNC_RSP       = 8'h5A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_fifo_empty,
   input  logic [7:0]  rx_fifo_dout,
   output logic        rx_fifo_rd_en,
   input  logic        tx_fifo_full,
   output logic        tx_fifo_wr_en,
   output logic [7:0]  tx_fifo_din,
   input  logic [7:0]  reg_rd_addr,
   output logic [7:0]  reg_rd_data,
   output logic        busy,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] err_count
);

   localparam int               c_ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int               c_TO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [8:0]       c_NUM_REGS9 = 9'(NUM_REGS);

   localparam logic [7:0] c_CMD_WR      = 8'h01;
   localparam logic [7:0] c_CMD_RD      = 8'h02;
   localparam logic [7:0] c_ST_OK       = 8'h00;
   localparam logic [7:0] c_ST_BAD_CHK  = 8'h01;
   localparam logic [7:0] c_ST_BAD_CMD  = 8'h02;
   localparam logic [7:0] c_ST_BAD_ADDR = 8'h03;

   typedef enum logic [2:0] {
      S_HUNT     = 3'd0,
      S_GET_CMD  = 3'd1,
      S_GET_ADDR = 3'd2,
      S_GET_DATA = 3'd3,
      S_GET_CHK  = 3'd4,
      S_EXEC     = 3'd5,
      S_RESP     = 3'd6
   } state_t;

   state_t              state_q,    state_d;
   logic                rd_en_q,    rd_en_d;     // pop strobe presented to the FIFO
   logic                vld_q,      vld_d;       // rx_fifo_dout carries a popped byte
   logic                discard_q,  discard_d;   // next popped byte belongs to an aborted frame
   logic [7:0]          cmd_q,      cmd_d;
   logic [7:0]          addr_q,     addr_d;
   logic [7:0]          data_q,     data_d;
   logic [7:0]          chk_q,      chk_d;
   logic [7:0]          status_q,   status_d;
   logic [7:0]          rdata_q,    rdata_d;
   logic [1:0]          idx_q,      idx_d;
   logic [c_TO_W-1:0]   tmo_q,      tmo_d;
   logic                frame_err_q, frame_err_d;
   logic [15:0]         err_cnt_q,  err_cnt_d;
   logic [7:0]          regs_q [NUM_REGS];
   logic [7:0]          regs_d [NUM_REGS];

   logic                w_chk_ok;
   logic                w_cmd_ok;
   logic                w_addr_ok;
   logic [7:0]          w_status;
   logic [c_ADDR_W-1:0] w_addr_idx;
   logic [7:0]          w_rsp_byte;
   logic                w_rx_state;

   // Frame decode used in EXEC, in priority order checksum, command, address.
   assign w_chk_ok   = ((cmd_q ^ addr_q ^ data_q) == chk_q);
   assign w_cmd_ok   = (cmd_q == c_CMD_WR) || (cmd_q == c_CMD_RD);
   assign w_addr_ok  = ({1'b0, addr_q} < c_NUM_REGS9);
   assign w_addr_idx = addr_q[c_ADDR_W-1:0];

   always_comb begin
      w_status = c_ST_OK;
      if (!w_chk_ok) begin
         w_status = c_ST_BAD_CHK;
      end else if (!w_cmd_ok) begin
         w_status = c_ST_BAD_CMD;
      end else if (!w_addr_ok) begin
         w_status = c_ST_BAD_ADDR;
      end
   end

   always_comb begin
      case (idx_q)
         2'd0:    w_rsp_byte = SYNC_RSP;
         2'd1:    w_rsp_byte = status_q;
         2'd2:    w_rsp_byte = rdata_q;
         default: w_rsp_byte = status_q ^ rdata_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      vld_d       = rd_en_q;
      discard_d   = discard_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      data_d      = data_q;
      chk_d       = chk_q;
      status_d    = status_q;
      rdata_d     = rdata_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      frame_err_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      regs_d      = regs_q;
      rd_en_d     = 1'b0;
      w_rx_state  = 1'b0;

      // A delivered byte always consumes any pending discard request.
      if (vld_q) begin
         discard_d = 1'b0;
      end

      case (state_q)
         S_HUNT: begin
            tmo_d = '0;
            if (vld_q && !discard_q && (rx_fifo_dout == SYNC_CMD)) begin
               state_d = S_GET_CMD;
            end
         end

         S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK: begin
            if (vld_q) begin
               tmo_d = '0;
               case (state_q)
                  S_GET_CMD: begin
                     cmd_d   = rx_fifo_dout;
                     state_d = S_GET_ADDR;
                  end
                  S_GET_ADDR: begin
                     addr_d  = rx_fifo_dout;
                     state_d = S_GET_DATA;
                  end
                  S_GET_DATA: begin
                     data_d  = rx_fifo_dout;
                     state_d = S_GET_CHK;
                  end
                  default: begin
                     chk_d   = rx_fifo_dout;
                     state_d = S_EXEC;
                  end
               endcase
            end else if (tmo_q == c_TO_LAST) begin
               // Abort. A pop issued this cycle still delivers a byte next
               // cycle; it belongs to the dead frame and must not be hunted.
               tmo_d       = '0;
               frame_err_d = 1'b1;
               state_d     = S_HUNT;
               discard_d   = rd_en_q;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         S_EXEC: begin
            status_d = w_status;
            idx_d    = 2'd0;
            state_d  = S_RESP;
            if (w_status == c_ST_OK) begin
               if (cmd_q == c_CMD_WR) begin
                  regs_d[w_addr_idx] = data_q;
                  rdata_d            = data_q;
               end else begin
                  rdata_d = regs_q[w_addr_idx];
               end
            end else begin
               rdata_d     = 8'h00;
               frame_err_d = 1'b1;
            end
         end

         S_RESP: begin
            if (!tx_fifo_full) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = S_HUNT;
               end
            end
         end

         default: begin
            state_d = S_HUNT;
         end
      endcase

      if (frame_err_d && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end

      // Pops are only issued for the state being entered, so no byte is ever
      // requested on the way into EXEC/RESP. The rd_en_q term keeps a single
      // pop outstanding: the FIFO's empty flag does not yet reflect it.
      w_rx_state = (state_d == S_HUNT)     || (state_d == S_GET_CMD)  ||
                   (state_d == S_GET_ADDR) || (state_d == S_GET_DATA) ||
                   (state_d == S_GET_CHK);
      rd_en_d    = w_rx_state && !rx_fifo_empty && !rd_en_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_HUNT;
         rd_en_q     <= 1'b0;
         vld_q       <= 1'b0;
         discard_q   <= 1'b0;
         cmd_q       <= 8'h00;
         addr_q      <= 8'h00;
         data_q      <= 8'h00;
         chk_q       <= 8'h00;
         status_q    <= 8'h00;
         rdata_q     <= 8'h00;
         idx_q       <= 2'd0;
         tmo_q       <= '0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= 16'h0000;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         state_q     <= state_d;
         rd_en_q     <= rd_en_d;
         vld_q       <= vld_d;
         discard_q   <= discard_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         chk_q       <= chk_d;
         status_q    <= status_d;
         rdata_q     <= rdata_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
         regs_q      <= regs_d;
      end
   end

   // The TX strobe must follow tx_fifo_full in the same cycle to avoid pushing
   // into a full FIFO, so the TX side and frame_done are decoded from state.
   assign tx_fifo_wr_en = (state_q == S_RESP) && !tx_fifo_full;
   assign tx_fifo_din   = (state_q == S_RESP) ? w_rsp_byte : 8'h00;
   assign frame_done    = tx_fifo_wr_en && (idx_q == 2'd3);
   assign busy          = (state_q != S_HUNT);
   assign rx_fifo_rd_en = rd_en_q;
   assign frame_err     = frame_err_q;
   assign err_count     = err_cnt_q;

   assign reg_rd_data = ({1'b0, reg_rd_addr} < c_NUM_REGS9) ?
                        regs_q[reg_rd_addr[c_ADDR_W-1:0]] : 8'h00;

endmodule
`default_nettype wire

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Host-side responder at the user end of the UART FIFOs.
- Pops command frames from the RX FIFO, decodes them, and executes register writes/reads on an internal register file.
- Pushes a fixed 4-byte response frame into the TX FIFO.
- Sits beside uart_top and connects to its rx_fifo_*/tx_fifo_* user ports, forming the far end of the serial command link.

Parameters:
- NUM_REGS, 16: number of 8-bit registers; valid addresses 0..NUM_REGS-1, NUM_REGS ≤ 256.
- TIMEOUT_CYCLES, 50000: maximum clk cycles between consecutive bytes within a frame before the frame is aborted.
- SYNC_CMD, 8'hA5: command frame start byte.
- SYNC_RSP, 8'h5A: response frame start byte.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- rx_fifo_empty, input, 1: RX FIFO empty.
- rx_fifo_dout, input, 8: RX FIFO data; valid the cycle after rx_fifo_rd_en.
- rx_fifo_rd_en, output, 1: RX FIFO pop strobe.
- tx_fifo_full, input, 1: TX FIFO full.
- tx_fifo_wr_en, output, 1: TX FIFO push strobe.
- tx_fifo_din, output, 8: TX FIFO push data.
- reg_rd_addr, input, 8: fabric-side register read address.
- reg_rd_data, output, 8: combinational read of regs[reg_rd_addr]; 0 if out of range.
- busy, output, 1: high in any state other than HUNT.
- frame_done, output, 1: one-cycle pulse when the last response byte is pushed.
- frame_err, output, 1: one-cycle pulse on timeout abort or non-OK status.
- err_count, output, 16: saturating count of frame_err pulses.

Behaviour:
- Reset (sync, rst=1 at posedge): state=HUNT; all regs=0; rx_fifo_rd_en=0, tx_fifo_wr_en=0, tx_fifo_din=0, busy=0, frame_done=0, frame_err=0, err_count=0; timeout counter cleared. Reset mid-frame discards the partial frame and emits no response.
- Command frame: SYNC_CMD, CMD, ADDR, DATA, CHK, where CHK = CMD^ADDR^DATA.
- Response frame: SYNC_RSP, STATUS, RDATA, RCHK, where RCHK = STATUS^RDATA.
- RX pop handshake: at most one pop outstanding. Assert rx_fifo_rd_en for exactly one cycle only when rx_fifo_empty=0 and no pop is pending. Sample rx_fifo_dout on the next cycle. Maximum RX throughput is 1 byte per 2 cycles.
- States:
  - HUNT: pop bytes. Byte==SYNC_CMD -> GET_CMD; any other byte is discarded, with no error.
  - GET_CMD -> GET_ADDR -> GET_DATA -> GET_CHK: each state captures one popped byte.
  - GET_CHK -> EXEC after the CHK byte is captured.
  - EXEC (1 cycle): compute STATUS in priority order:
    - 8'h01 if checksum mismatch;
    - 8'h02 if CMD not in {8'h01 write, 8'h02 read};
    - 8'h03 if ADDR ≥ NUM_REGS;
    - otherwise 8'h00.
  - EXEC actions:
    - Write with OK: regs[ADDR] <= DATA; RDATA = DATA.
    - Read with OK: RDATA = regs[ADDR] (value before any same-cycle update).
    - Non-OK: RDATA = 8'h00, no register change, frame_err pulses.
    - Then -> RESP with byte index 0.
  - RESP: push bytes 0..3 in order; one push per cycle while tx_fifo_full=0; stall with tx_fifo_wr_en=0 while full. frame_done pulses together with the 4th push; -> HUNT the next cycle. No RX pops occur during EXEC/RESP.
- Timeout: in GET_* states the counter resets on each captured byte and increments otherwise. On reaching TIMEOUT_CYCLES: frame_err pulses, -> HUNT, no response, and a pending pop's byte is discarded.
- A SYNC_CMD byte arriving mid-frame is treated as ordinary data; no resync.
- err_count increments on each frame_err pulse and saturates at 16'hFFFF.
- reg_rd_data reflects a write on the cycle after EXEC.

Test Plan:
- Write frame A5 01 03 7E 7C (CHK=01^03^7E=7C), TX FIFO empty -> regs[3]=7E; TX bytes 5A 00 7E 7E; frame_done one pulse; reg_rd_addr=3 gives reg_rd_data=7E.
- Read frame A5 02 03 00 01 after the previous write -> TX bytes 5A 00 7E 7E; regs unchanged.
- Bad checksum A5 01 02 11 00 -> TX bytes 5A 01 00 01; regs[2] stays 00; frame_err pulse; err_count=1. Bad address A5 01 10 55 44 (NUM_REGS=16) -> TX bytes 5A 03 00 03.
- Garbage 00 FF 13 before a valid read frame -> garbage is dropped silently; exactly one 4-byte response; err_count unchanged.
- Hold tx_fifo_full=1 for 20 cycles at RESP byte index 2 -> tx_fifo_wr_en stays 0 for those cycles; byte order preserved; no RX pops while in RESP.
- Send A5 01 then stop sending with TIMEOUT_CYCLES=100 -> frame_err pulses 100 cycles after the last byte; state returns to HUNT; no TX push. Separately, assert rst mid-RESP -> all outputs at reset values the next cycle.
